// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave front-end: FSM encoding, mode-bit values
// and default word widths.
package spi_pkg;

    localparam int DEFAULT_CMD_W  = 2;
    localparam int DEFAULT_DATA_W = 8;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4,
        TX_WAIT   = 3'd5,
        TX_SHIFT  = 3'd6,
        DONE      = 3'd7
    } state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// Parametrised-width shift register with parallel load and MSB-first shift.
// Load takes priority over shift.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic         shift_in,
    output logic [W-1:0] q
);

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[W-2:0], shift_in};
        end
    end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave front-end: deserialises MOSI into command+data words for the RAM
// and serialises RAM read data back on MISO.
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CMD_W  = DEFAULT_CMD_W,
    parameter int RX_W   = CMD_W + DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic [RX_W-1:0]   rx_data,
    output logic              rx_valid,
    output logic              MISO,
    output logic              frame_err,
    output logic              rd_pend
);

    localparam int CNT_W = $clog2(RX_W + 1);
    localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_W - 1);
    localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(DATA_W - 1);

    state_t state, next_state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [RX_W-2:0]   rx_q;
    logic [DATA_W-1:0] tx_q;

    logic rx_shift, rx_done, set_pend, clr_pend, abort;
    logic tx_load, tx_shift, cnt_clr;

    // The final received bit joins the word straight from MOSI, so the rx
    // register only holds the leading RX_W-1 bits.
    spi_shift_reg #(.W(RX_W - 1)) u_rx_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift),
        .shift_in  (MOSI),
        .q         (rx_q)
    );

    spi_shift_reg #(.W(DATA_W)) u_tx_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (tx_load),
        .load_data (tx_data),
        .shift     (tx_shift),
        .shift_in  (1'b0),
        .q         (tx_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        next_state = state;
        rx_shift   = 1'b0;
        rx_done    = 1'b0;
        set_pend   = 1'b0;
        clr_pend   = 1'b0;
        abort      = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        cnt_clr    = 1'b0;
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (!SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                cnt_clr = 1'b1;
                if (SS_n) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (MOSI == MODE_WRITE) begin
                    next_state = WRITE;
                end else begin
                    next_state = rd_pend ? READ_DATA : READ_ADD;
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                // The last bit completes the frame even if SS_n rises on that edge.
                if (bit_cnt == RX_LAST) begin
                    rx_done  = 1'b1;
                    set_pend = (state == READ_ADD);
                    clr_pend = (state == READ_DATA);
                    if (SS_n)                    next_state = IDLE;
                    else if (state == READ_DATA) next_state = TX_WAIT;
                    else                         next_state = DONE;
                end else if (SS_n) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else begin
                    rx_shift = 1'b1;
                end
            end
            TX_WAIT: begin
                cnt_clr = 1'b1;
                if (SS_n) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else if (tx_valid) begin
                    tx_load    = 1'b1;
                    next_state = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (SS_n) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else begin
                    tx_shift = 1'b1;
                    if (bit_cnt == TX_LAST) next_state = DONE;
                end
            end
            DONE: begin
                if (SS_n) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            MISO      <= 1'b0;
            frame_err <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (rx_shift || tx_shift) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (rx_done) rx_data <= {rx_q, MOSI};
            rx_valid  <= rx_done;
            frame_err <= abort;
            // MISO is registered, so each bit appears one edge after it is shifted out.
            MISO      <= tx_shift ? tx_q[DATA_W-1] : 1'b0;
            if (set_pend) begin
                rd_pend <= 1'b1;
            end else if (clr_pend) begin
                rd_pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: default 8-bit instance plus a 16-bit
// instance for the wide-frame and wide-MISO cases.
module tb_spi_slave_ctrl;
    import spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss_n = 1'b1;
    logic        mosi = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic [9:0]  rx_data;
    logic        rx_valid, miso, frame_err, rd_pend;

    logic        ss2 = 1'b1;
    logic        mosi2 = 1'b0;
    logic        txv2 = 1'b0;
    logic [15:0] txd2 = 16'h0000;
    logic [17:0] rxd2;
    logic        rxv2, miso2, ferr2, pend2;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  exp_c3   = 8'hC3;
    logic [15:0] exp_beef = 16'hBEEF;

    always #5 clk = ~clk;

    spi_slave_ctrl dut8 (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (ss_n),
        .MOSI      (mosi),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .MISO      (miso),
        .frame_err (frame_err),
        .rd_pend   (rd_pend)
    );

    spi_slave_ctrl #(.DATA_W(16), .CMD_W(2)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .SS_n      (ss2),
        .MOSI      (mosi2),
        .tx_data   (txd2),
        .tx_valid  (txv2),
        .rx_data   (rxd2),
        .rx_valid  (rxv2),
        .MISO      (miso2),
        .frame_err (ferr2),
        .rd_pend   (pend2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives the top n bits of a 10-bit word onto MOSI, one per edge.
    task automatic send8(input logic [9:0] bits, input int n);
        for (int i = 9; i > 9 - n; i--) begin
            mosi = bits[i];
            tick();
        end
    endtask

    task automatic start8(input logic mode);
        ss_n = 1'b0;
        tick();
        mosi = mode;
        tick();
    endtask

    task automatic send16(input logic [17:0] bits);
        for (int i = 17; i >= 0; i--) begin
            mosi2 = bits[i];
            tick();
        end
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_miso", miso, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_rd_pend", rd_pend, 0);
        tick();
        rst = 1'b0;
        tick();

        // Write frame 0x0A5, tx_valid held high and ignored
        tx_valid = 1'b1;
        start8(MODE_WRITE);
        send8(10'h0A5, 9);
        chk("wr_no_early_valid", rx_valid, 0);
        chk("wr_miso_low", miso, 0);
        mosi = 1'b1;
        tick();
        chk("wr_rx_valid", rx_valid, 1);
        chk("wr_rx_data", rx_data, 10'h0A5);
        chk("wr_no_ferr", frame_err, 0);
        chk("wr_miso_after", miso, 0);
        tick();
        chk("wr_valid_one_cycle", rx_valid, 0);
        tx_valid = 1'b0;
        ss_n = 1'b1;
        tick();
        chk("wr_end_no_ferr", frame_err, 0);

        // Read address frame
        start8(MODE_READ);
        send8(10'h203, 10);
        chk("ra_rx_valid", rx_valid, 1);
        chk("ra_rx_data", rx_data, 10'h203);
        chk("ra_rd_pend", rd_pend, 1);
        ss_n = 1'b1;
        tick();

        // Read data frame, late tx_valid, MISO serialisation of 0xC3
        start8(MODE_READ);
        send8(10'h300, 10);
        chk("rd_rx_valid", rx_valid, 1);
        chk("rd_rx_data", rx_data, 10'h300);
        chk("rd_pend_clr", rd_pend, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rd_wait_miso", miso, 0);
        end
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        chk("rd_load_miso", miso, 0);
        for (int i = 7; i >= 0; i--) begin
            tick();
            chk("rd_miso_bit", miso, exp_c3[i]);
        end
        tick();
        chk("rd_miso_idle", miso, 0);
        ss_n = 1'b1;
        tick();
        chk("rd_no_ferr", frame_err, 0);

        // Abort after 4 write data bits
        start8(MODE_WRITE);
        send8(10'h3FF, 4);
        ss_n = 1'b1;
        tick();
        chk("ab_ferr", frame_err, 1);
        chk("ab_no_valid", rx_valid, 0);
        chk("ab_rx_kept", rx_data, 10'h300);
        tick();
        chk("ab_ferr_one_cycle", frame_err, 0);
        chk("ab_rx_still", rx_data, 10'h300);

        // SS_n rises on the edge sampling the last write bit
        start8(MODE_WRITE);
        send8(10'h1C3, 9);
        mosi = 1'b1;
        ss_n = 1'b1;
        tick();
        chk("bd_rx_valid", rx_valid, 1);
        chk("bd_rx_data", rx_data, 10'h1C3);
        chk("bd_no_ferr", frame_err, 0);
        chk("bd_state_idle", dut8.state, IDLE);
        tick();
        chk("bd_no_ferr_after", frame_err, 0);

        // 16-bit instance: 18-bit frame and 16-bit MISO word
        ss2 = 1'b0;
        tick();
        mosi2 = MODE_READ;
        tick();
        send16(18'h21234);
        chk("w16_rx_valid", rxv2, 1);
        chk("w16_rx_data", rxd2, 18'h21234);
        chk("w16_rd_pend", pend2, 1);
        ss2 = 1'b1;
        tick();
        txd2 = 16'hBEEF;
        txv2 = 1'b1;
        ss2  = 1'b0;
        tick();
        mosi2 = MODE_READ;
        tick();
        send16(18'h30000);
        chk("w16_rd_data", rxd2, 18'h30000);
        chk("w16_pend_clr", pend2, 0);
        chk("w16_miso_pre", miso2, 0);
        tick();
        txv2 = 1'b0;
        chk("w16_load_miso", miso2, 0);
        for (int i = 15; i >= 0; i--) begin
            tick();
            chk("w16_miso_bit", miso2, exp_beef[i]);
        end
        tick();
        chk("w16_miso_idle", miso2, 0);
        ss2 = 1'b1;
        tick();
        chk("w16_no_ferr", ferr2, 0);

        // Asynchronous reset while rd_pend is set, mid-frame
        start8(MODE_READ);
        send8(10'h2A5, 10);
        chk("rs_pend_set", rd_pend, 1);
        ss_n = 1'b1;
        tick();
        start8(MODE_READ);
        send8(10'h3FF, 3);
        rst = 1'b1;
        #1;
        chk("rs_rx_data", rx_data, 0);
        chk("rs_rx_valid", rx_valid, 0);
        chk("rs_miso", miso, 0);
        chk("rs_ferr", frame_err, 0);
        chk("rs_rd_pend", rd_pend, 0);
        chk("rs_state", dut8.state, IDLE);
        tick();
        ss_n = 1'b1;
        rst  = 1'b0;
        tick();
        start8(MODE_READ);
        send8(10'h155, 10);
        chk("rs_after_valid", rx_valid, 1);
        chk("rs_after_data", rx_data, 10'h155);
        chk("rs_after_read_add", rd_pend, 1);
        ss_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
